// File: rtl/mem_arbiter.sv
// Two-client (I-cache / D-cache) arbiter onto a single block-wide memory port.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise D wins ties.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 28,
    parameter int DATA_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  i_read,
    input  logic                  i_write,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic                  i_ready,
    output logic [DATA_WIDTH-1:0] i_rdata,

    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_ready,
    output logic [DATA_WIDTH-1:0] d_rdata,

    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t                state, state_nxt;
    logic                  lat_write, lat_write_nxt;
    logic [ADDR_WIDTH-1:0] lat_addr, lat_addr_nxt;
    logic [DATA_WIDTH-1:0] lat_wdata, lat_wdata_nxt;

    logic i_req, d_req;
    logic grant_i, grant_d;

    assign i_req = i_read | i_write;
    assign d_req = d_read | d_write;

`ifdef MEM_ARB_RR_EN
    // last_d: 1 when the most recent grant went to D, 0 when it went to I
    logic last_d;

    always_comb begin
        grant_d = d_req & (~i_req | ~last_d);
        grant_i = i_req & ~grant_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_d <= 1'b0;
        end else if (state == IDLE && (i_req || d_req)) begin
            last_d <= grant_d;
        end
    end
`else
    always_comb begin
        grant_d = d_req;
        grant_i = i_req & ~d_req;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else begin
            state     <= state_nxt;
            lat_write <= lat_write_nxt;
            lat_addr  <= lat_addr_nxt;
            lat_wdata <= lat_wdata_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        lat_write_nxt = lat_write;
        lat_addr_nxt  = lat_addr;
        lat_wdata_nxt = lat_wdata;
        i_ready       = 1'b0;
        d_ready       = 1'b0;

        case (state)
            IDLE: begin
                if (grant_d) begin
                    state_nxt     = BUSY_D;
                    lat_write_nxt = d_write;
                    lat_addr_nxt  = d_addr;
                    lat_wdata_nxt = d_wdata;
                end else if (grant_i) begin
                    state_nxt     = BUSY_I;
                    lat_write_nxt = i_write;
                    lat_addr_nxt  = i_addr;
                    lat_wdata_nxt = i_wdata;
                end
            end
            BUSY_I: begin
                if (mem_ready) begin
                    i_ready   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            BUSY_D: begin
                if (mem_ready) begin
                    d_ready   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes decode from the state register so an async reset drops them at once
    always_comb begin
        mem_read  = (state != IDLE) & ~lat_write;
        mem_write = (state != IDLE) &  lat_write;
        mem_addr  = lat_addr;
        mem_wdata = lat_wdata;
    end

    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboarded bench for mem_arbiter: per-client expected-transaction queues,
// a memory responder task that checks each granted transaction and its handshake.
module tb_mem_arbiter;

    localparam int AW = 28;
    localparam int DW = 128;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_read, i_write, d_read, d_write;
    logic [AW-1:0] i_addr, d_addr;
    logic [DW-1:0] i_wdata, d_wdata;
    logic          i_ready, d_ready;
    logic [DW-1:0] i_rdata, d_rdata;
    logic          mem_read, mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_ready(i_ready), .i_rdata(i_rdata),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } txn_t;

    txn_t q_i[$];
    txn_t q_d[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic req(input logic is_d, input logic rd, input logic wr,
                       input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        txn_t t;
        t.wr = wr; t.addr = addr; t.wdata = wdata;
        if (is_d) begin
            d_read = rd; d_write = wr; d_addr = addr; d_wdata = wdata;
            q_d.push_back(t);
        end else begin
            i_read = rd; i_write = wr; i_addr = addr; i_wdata = wdata;
            q_i.push_back(t);
        end
    endtask

    // Waits for the next grant, checks it against the client's queue, holds for
    // 'delay' extra cycles, then pulses mem_ready. In the ready cycle the granted
    // client either drops its request or presents the follow-on request (nv).
    task automatic serve(input logic exp_d, input int delay, input logic wiggle,
                         input logic [DW-1:0] rdata, input logic nv, input logic nwr,
                         input logic [AW-1:0] na, input logic [DW-1:0] nwd);
        int   n;
        txn_t e;
        logic [AW-1:0] ha;
        logic [DW-1:0] hd;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            n++;
            if (mem_read || mem_write) break;
        end
        if (!(mem_read || mem_write)) begin
            check("grant_timeout", 1'b0, 1'b1);
            return;
        end
        check("grant_latency", n, 1);
        if ((exp_d && q_d.size() == 0) || (!exp_d && q_i.size() == 0)) begin
            check("sb_empty", 1'b0, 1'b1);
            return;
        end
        e = exp_d ? q_d.pop_front() : q_i.pop_front();
        check("mem_write", mem_write, e.wr);
        check("mem_read", mem_read, !e.wr);
        check("mem_addr", mem_addr, e.addr);
        check("mem_wdata", mem_wdata, e.wdata);
        ha = mem_addr;
        hd = mem_wdata;
        for (int c = 0; c < delay; c++) begin
            if (wiggle) begin
                d_addr  = d_addr ^ AW'($urandom);
                d_wdata = {$urandom, $urandom, $urandom, $urandom};
                d_write = 1'b0;
                d_read  = 1'b0;
            end
            @(negedge clk);
            #1;
            check("hold_addr", mem_addr, ha);
            check("hold_wdata", mem_wdata, hd);
            check("hold_strobe", {mem_write, mem_read}, {e.wr, !e.wr});
            check("early_ready", {i_ready, d_ready}, 2'b00);
        end
        mem_ready = 1'b1;
        mem_rdata = rdata;
        if (exp_d) begin
            d_read = nv & ~nwr; d_write = nv & nwr;
            if (nv) req(1'b1, ~nwr, nwr, na, nwd);
        end else begin
            i_read = nv & ~nwr; i_write = nv & nwr;
            if (nv) req(1'b0, ~nwr, nwr, na, nwd);
        end
        #1;
        check("i_ready", i_ready, !exp_d);
        check("d_ready", d_ready, exp_d);
        check("i_rdata", i_rdata, rdata);
        check("d_rdata", d_rdata, rdata);
        // Keep mem_ready high into the IDLE cycle: it must not create a second pulse
        @(negedge clk);
        #1;
        check("idle_strobe", {mem_write, mem_read}, 2'b00);
        check("idle_ready", {i_ready, d_ready}, 2'b00);
        check("idle_addr_hold", mem_addr, ha);
        mem_ready = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] a5;
        logic          is_d, rd, wr;
        logic [AW-1:0] ra;
        int            n;

        rst = 1'b1;
        i_read = 0; i_write = 0; i_addr = '0; i_wdata = '0;
        d_read = 0; d_write = 0; d_addr = '0; d_wdata = '0;
        mem_rdata = '0; mem_ready = 0;
        repeat (3) @(negedge clk);
        check("rst_strobe", {mem_write, mem_read}, 2'b00);
        check("rst_addr", mem_addr, '0);
        check("rst_wdata", mem_wdata, '0);
        check("rst_ready", {i_ready, d_ready}, 2'b00);
        rst = 1'b0;

        // Reset in the middle of a D write
        @(negedge clk);
        req(1'b1, 1'b0, 1'b1, 28'h0000060, 128'hDEAD_BEEF);
        n = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            n++;
            if (mem_write) break;
        end
        check("rst_pre_write", mem_write, 1'b1);
        @(negedge clk);
        mem_ready = 1'b1;
        rst = 1'b1;
        #1;
        check("rst_mid_write", mem_write, 1'b0);
        check("rst_mid_addr", mem_addr, '0);
        check("rst_mid_wdata", mem_wdata, '0);
        check("rst_mid_ready", {i_ready, d_ready}, 2'b00);
        d_write = 1'b0;
        void'(q_d.pop_front());
        mem_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        check("post_rst_ready", {i_ready, d_ready}, 2'b00);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        check("post_rst_strobe", {mem_write, mem_read}, 2'b00);

        // Single I read, memory ready 3 cycles after mem_read
        a5 = {16{8'hA5}};
        req(1'b0, 1'b1, 1'b0, 28'h0000010, '0);
        serve(1'b0, 3, 1'b0, a5, 1'b0, 1'b0, '0, '0);

        // Tie: I read 0x10 vs D write 0x20; D re-requests in its ready cycle
        req(1'b0, 1'b1, 1'b0, 28'h0000010, '0);
        req(1'b1, 1'b0, 1'b1, 28'h0000020, 128'h1234);
        serve(1'b1, 1, 1'b0, 128'h1, 1'b1, 1'b0, 28'h0000024, '0);
`ifdef MEM_ARB_RR_EN
        serve(1'b0, 0, 1'b0, 128'h2, 1'b0, 1'b0, '0, '0);
        serve(1'b1, 0, 1'b0, 128'h3, 1'b0, 1'b0, '0, '0);
`else
        serve(1'b1, 0, 1'b0, 128'h2, 1'b0, 1'b0, '0, '0);
        serve(1'b0, 0, 1'b0, 128'h3, 1'b0, 1'b0, '0, '0);
`endif

        // Write-back then fetch from D, back to back
        req(1'b1, 1'b0, 1'b1, 28'h0000030, 128'hCAFE);
        serve(1'b1, 2, 1'b0, 128'h4, 1'b1, 1'b0, 28'h0000040, '0);
        serve(1'b1, 0, 1'b0, 128'h5, 1'b0, 1'b0, '0, '0);

        // Client inputs change and request drops while BUSY_D
        req(1'b1, 1'b0, 1'b1, 28'h0000050, 128'h5555_AAAA);
        serve(1'b1, 3, 1'b1, 128'h6, 1'b0, 1'b0, '0, '0);

        // mem_ready while IDLE is ignored
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        check("idle_mem_ready", {i_ready, d_ready}, 2'b00);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        check("idle_no_grant", {mem_write, mem_read}, 2'b00);

        // Random single-client transactions, including read+write together
        for (int k = 0; k < 10; k++) begin
            is_d = 1'($urandom);
            rd   = 1'($urandom);
            wr   = 1'($urandom);
            if (!rd && !wr) rd = 1'b1;
            ra   = AW'($urandom);
            req(is_d, rd, wr, ra, {$urandom, $urandom, $urandom, $urandom});
            serve(is_d, int'($urandom_range(0, 3)), 1'b0,
                  {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0, '0, '0);
        end

        check("sb_i_drained", q_i.size(), 0);
        check("sb_d_drained", q_d.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
